// File: rtl/dmem_pkg.sv
// Shared address map, STATUS bit positions and address decode for the data-memory responder.
// Imported by the RTL and by its testbench.
package dmem_pkg;

    localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
    localparam logic [31:0] GPIO_ADDR   = 32'h0000_8000;
    localparam logic [31:0] TCOUNT_ADDR = 32'h0000_8004;
    localparam logic [31:0] TCMP_ADDR   = 32'h0000_8008;
    localparam logic [31:0] STATUS_ADDR = 32'h0000_800C;

    localparam int STATUS_IRQ_BIT = 0;
    localparam int STATUS_MIS_BIT = 1;

    typedef enum logic [2:0] {
        RGN_RAM,
        RGN_GPIO,
        RGN_TCOUNT,
        RGN_TCMP,
        RGN_STATUS,
        RGN_NONE
    } region_e;

    // The RAM occupies the bottom of the map and everything else is a single register.
    function automatic region_e decode_region(input logic [31:0] addr, input logic [31:0] ram_bytes);
        region_e rgn;
        if ((addr - RAM_BASE) < ram_bytes) begin
            rgn = RGN_RAM;
        end else begin
            case (addr)
                GPIO_ADDR:   rgn = RGN_GPIO;
                TCOUNT_ADDR: rgn = RGN_TCOUNT;
                TCMP_ADDR:   rgn = RGN_TCMP;
                STATUS_ADDR: rgn = RGN_STATUS;
                default:     rgn = RGN_NONE;
            endcase
        end
        return rgn;
    endfunction

endpackage

// File: rtl/dmem_timer.sv
// Free-running 32-bit timer with compare register and a sticky match-pending flag.
// A compare write and a pending-flag clear both act at the edge they are presented.
module dmem_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmp_we_i,
    input  logic [31:0] cmp_wdata_i,
    input  logic        irq_clr_i,
    output logic [31:0] count_o,
    output logic [31:0] cmp_o,
    output logic        irq_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] cmp_q, cmp_d;
    logic        irq_q, irq_d;
    logic        match_s;

    // Next-state: the match compares the incoming count against the compare value held before this edge.
    always_comb begin
        count_d = count_q + 32'd1;
        match_s = (count_d == cmp_q);
        if (cmp_we_i) begin
            cmp_d = cmp_wdata_i;
        end else begin
            cmp_d = cmp_q;
        end
        if (match_s) begin
            irq_d = 1'b1;
        end else if (irq_clr_i) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 32'h0000_0000;
            cmp_q   <= 32'hFFFF_FFFF;
            irq_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            cmp_q   <= cmp_d;
            irq_q   <= irq_d;
        end
    end

    assign count_o = count_q;
    assign cmp_o   = cmp_q;
    assign irq_o   = irq_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for a single-cycle core: word RAM, GPIO, timer and STATUS registers.
// Reads are combinational; writes and status updates land on the rising edge.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int GPIO_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dmem_wren,
    input  logic [31:0]       dmem_addr,
    input  logic [31:0]       dmem_data_in,
    output logic [31:0]       dmem_data_out,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              irq_timer,
    output logic              err_misaligned
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

    logic [31:0]       ram_q [DEPTH];
    region_e           rgn_s;
    logic              misaligned_s;
    logic              wr_ok_s;
    logic              status_wr_s;
    logic [AW-1:0]     widx_s;
    logic [GPIO_W-1:0] gpio_q, gpio_d;
    logic              mis_q, mis_d;
    logic [31:0]       count_s, cmp_s, status_s, rdata_s;
    logic              irq_s;

    // Address decode and write qualification; misaligned addresses never write anything.
    always_comb begin
        misaligned_s = (dmem_addr[1:0] != 2'b00);
        rgn_s        = decode_region(dmem_addr, RAM_BYTES);
        wr_ok_s      = dmem_wren & ~misaligned_s;
        widx_s       = dmem_addr[AW+1:2];
        status_wr_s  = wr_ok_s && (rgn_s == RGN_STATUS);
    end

    // GPIO and misaligned-flag next state; a new misalignment wins over a same-edge clear.
    always_comb begin
        if (wr_ok_s && (rgn_s == RGN_GPIO)) begin
            gpio_d = dmem_data_in[GPIO_W-1:0];
        end else begin
            gpio_d = gpio_q;
        end
        if (misaligned_s) begin
            mis_d = 1'b1;
        end else if (status_wr_s && dmem_data_in[STATUS_MIS_BIT]) begin
            mis_d = 1'b0;
        end else begin
            mis_d = mis_q;
        end
    end

    dmem_timer u_timer (
        .clk         (clk),
        .rst_n       (reset),
        .cmp_we_i    (wr_ok_s && (rgn_s == RGN_TCMP)),
        .cmp_wdata_i (dmem_data_in),
        .irq_clr_i   (status_wr_s && dmem_data_in[STATUS_IRQ_BIT]),
        .count_o     (count_s),
        .cmp_o       (cmp_s),
        .irq_o       (irq_s)
    );

    // Read mux: held at zero during reset and for misaligned or unmapped addresses.
    always_comb begin
        status_s                 = 32'h0000_0000;
        status_s[STATUS_IRQ_BIT] = irq_s;
        status_s[STATUS_MIS_BIT] = mis_q;
        rdata_s                  = 32'h0000_0000;
        if (!reset) begin
            rdata_s = 32'h0000_0000;
        end else if (misaligned_s) begin
            rdata_s = 32'h0000_0000;
        end else begin
            case (rgn_s)
                RGN_RAM:    rdata_s = ram_q[widx_s];
                RGN_GPIO:   rdata_s = 32'(gpio_q);
                RGN_TCOUNT: rdata_s = count_s;
                RGN_TCMP:   rdata_s = cmp_s;
                RGN_STATUS: rdata_s = status_s;
                default:    rdata_s = 32'h0000_0000;
            endcase
        end
    end

    // RAM has no reset so its contents survive one; stores are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (reset && wr_ok_s && (rgn_s == RGN_RAM)) begin
            ram_q[widx_s] <= dmem_data_in;
        end
    end

    // GPIO and misaligned-status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_q <= '0;
            mis_q  <= 1'b0;
        end else begin
            gpio_q <= gpio_d;
            mis_q  <= mis_d;
        end
    end

    assign dmem_data_out  = rdata_s;
    assign gpio_out       = gpio_q;
    assign irq_timer      = irq_s;
    assign err_misaligned = mis_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table for the register/RAM map,
// then hand-written reset, timer-match and wrap-around sequences.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH  = 256;
    localparam int GPIO_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              dmem_wren = 1'b0;
    logic [31:0]       dmem_addr = 32'h0;
    logic [31:0]       dmem_data_in = 32'h0;
    logic [31:0]       dmem_data_out;
    logic [GPIO_W-1:0] gpio_out;
    logic              irq_timer;
    logic              err_misaligned;

    dmem_responder #(.DEPTH(DEPTH), .GPIO_W(GPIO_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .dmem_wren      (dmem_wren),
        .dmem_addr      (dmem_addr),
        .dmem_data_in   (dmem_data_in),
        .dmem_data_out  (dmem_data_out),
        .gpio_out       (gpio_out),
        .irq_timer      (irq_timer),
        .err_misaligned (err_misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } sb_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        chk;
        logic [31:0] rd;
        logic [7:0]  gpio;
        logic        err;
    } vec_t;

    sb_t  rd_q[$];
    sb_t  st_q[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] dut_out(input int sel);
        case (sel)
            0:       return dmem_data_out;
            1:       return 32'(gpio_out);
            2:       return {31'h0, irq_timer};
            default: return {31'h0, err_misaligned};
        endcase
    endfunction

    task automatic compare(input sb_t e);
        logic [31:0] got;
        got = dut_out(e.sel);
        checks++;
        if (got !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
        end
    endtask

    task automatic drain_rd();
        while (rd_q.size() > 0) compare(rd_q.pop_front());
    endtask

    task automatic drain_st();
        while (st_q.size() > 0) compare(st_q.pop_front());
    endtask

    task automatic push_outputs(input string tag, input logic [7:0] g, input logic irq, input logic err);
        st_q.push_back('{{tag, ".gpio"}, 1, 32'(g)});
        st_q.push_back('{{tag, ".irq"}, 2, {31'h0, irq}});
        st_q.push_back('{{tag, ".err"}, 3, {31'h0, err}});
    endtask

    // One bus cycle starting at a falling edge: drive, check the combinational read, then the flops after the edge.
    task automatic cycle(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic chk,
                         input logic [31:0] rd, input logic [7:0] g, input logic irq, input logic err,
                         input string tag);
        dmem_wren    = wr;
        dmem_addr    = a;
        dmem_data_in = d;
        if (chk) rd_q.push_back('{{tag, ".rd"}, 0, rd});
        push_outputs(tag, g, irq, err);
        #1;
        drain_rd();
        @(negedge clk);
        drain_st();
    endtask

    task automatic add_vec(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic chk,
                           input logic [31:0] rd, input logic [7:0] g, input logic err);
        vecs.push_back('{wr, a, d, chk, rd, g, err});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic exp_irq;

        add_vec(1'b1, 32'h0000_0000, 32'h0000_0ABC, 1'b0, 32'h0,         8'h00, 1'b0);
        add_vec(1'b1, 32'h0000_0014, 32'hCAFE_F00D, 1'b0, 32'h0,         8'h00, 1'b0);
        add_vec(1'b1, 32'h0000_0010, 32'h1111_1111, 1'b0, 32'h0,         8'h00, 1'b0);
        add_vec(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'h1111_1111, 8'h00, 1'b0);
        add_vec(1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 8'h00, 1'b0);
        add_vec(1'b0, 32'h0000_0014, 32'h0,         1'b1, 32'hCAFE_F00D, 8'h00, 1'b0);
        add_vec(1'b1, GPIO_ADDR,     32'hFFFF_FFA5, 1'b1, 32'h0,         8'hA5, 1'b0);
        add_vec(1'b0, GPIO_ADDR,     32'h0,         1'b1, 32'h0000_00A5, 8'hA5, 1'b0);
        add_vec(1'b0, TCMP_ADDR,     32'h0,         1'b1, 32'hFFFF_FFFF, 8'hA5, 1'b0);
        add_vec(1'b1, TCMP_ADDR,     32'h1000_0000, 1'b1, 32'hFFFF_FFFF, 8'hA5, 1'b0);
        add_vec(1'b0, TCMP_ADDR,     32'h0,         1'b1, 32'h1000_0000, 8'hA5, 1'b0);
        add_vec(1'b1, 32'h0000_0012, 32'h1234_5678, 1'b1, 32'h0,         8'hA5, 1'b1);
        add_vec(1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 8'hA5, 1'b1);
        add_vec(1'b0, STATUS_ADDR,   32'h0,         1'b1, 32'h0000_0002, 8'hA5, 1'b1);
        add_vec(1'b1, STATUS_ADDR,   32'h0000_0002, 1'b1, 32'h0000_0002, 8'hA5, 1'b0);
        add_vec(1'b0, 32'h0000_8001, 32'h0,         1'b1, 32'h0,         8'hA5, 1'b1);
        add_vec(1'b1, STATUS_ADDR,   32'h0000_0001, 1'b1, 32'h0000_0002, 8'hA5, 1'b1);
        add_vec(1'b1, STATUS_ADDR,   32'h0000_0002, 1'b1, 32'h0000_0002, 8'hA5, 1'b0);
        add_vec(1'b0, 32'h0000_4000, 32'h0,         1'b1, 32'h0,         8'hA5, 1'b0);
        add_vec(1'b1, 32'h0000_4000, 32'hFFFF_FFFF, 1'b1, 32'h0,         8'hA5, 1'b0);
        add_vec(1'b0, 32'h0000_4000, 32'h0,         1'b1, 32'h0,         8'hA5, 1'b0);
        add_vec(1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h0000_0ABC, 8'hA5, 1'b0);
        add_vec(1'b0, GPIO_ADDR,     32'h0,         1'b1, 32'h0000_00A5, 8'hA5, 1'b0);

        // Power-on reset: compare register would read all-ones if the read were not forced low.
        dmem_addr = TCMP_ADDR;
        @(negedge clk);
        rd_q.push_back('{"por.rd", 0, 32'h0});
        drain_rd();
        push_outputs("por", 8'h00, 1'b0, 1'b0);
        drain_st();
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].chk, vecs[i].rd,
                  vecs[i].gpio, 1'b0, vecs[i].err, $sformatf("vec%0d", i));
        end

        // Set the sticky error so the mid-run reset has something to clear.
        cycle(1'b0, 32'h0000_8002, 32'h0, 1'b1, 32'h0, 8'hA5, 1'b0, 1'b1, "pre_rst");

        // Asynchronous reset mid-cycle with a store held on the bus.
        dmem_wren    = 1'b1;
        dmem_addr    = 32'h0000_0010;
        dmem_data_in = 32'h5555_5555;
        #2 reset = 1'b0;
        #1;
        rd_q.push_back('{"rst_async.rd", 0, 32'h0});
        drain_rd();
        push_outputs("rst_async", 8'h00, 1'b0, 1'b0);
        drain_st();
        repeat (2) @(negedge clk);
        push_outputs("rst_hold", 8'h00, 1'b0, 1'b0);
        drain_st();
        reset = 1'b1;

        // Timer: compare set to 20 right after release; W1C lands on the match edge and later clears.
        for (int k = 0; k < 25; k++) begin
            exp_irq = ((k + 1) >= 20) && ((k + 1) < 22);
            if (k == 0) begin
                cycle(1'b1, TCMP_ADDR, 32'd20, 1'b1, 32'hFFFF_FFFF, 8'h00, exp_irq, 1'b0, "tcmp_wr");
            end else if (k == 1) begin
                cycle(1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF, 8'h00, exp_irq, 1'b0, "ram_kept");
            end else if (k == 19) begin
                cycle(1'b1, STATUS_ADDR, 32'h1, 1'b1, 32'h0, 8'h00, exp_irq, 1'b0, "w1c_on_match");
            end else if (k == 21) begin
                cycle(1'b1, STATUS_ADDR, 32'h1, 1'b1, 32'h1, 8'h00, exp_irq, 1'b0, "w1c_clear");
            end else begin
                cycle(k == 5, TCOUNT_ADDR, 32'h0, 1'b1, 32'(k), 8'h00, exp_irq, 1'b0,
                      $sformatf("count%0d", k));
            end
        end

        // Wrap-around via deposit into the count register.
        dut.u_timer.count_q = 32'hFFFF_FFFE;
        cycle(1'b0, TCOUNT_ADDR, 32'h0, 1'b1, 32'hFFFF_FFFE, 8'h00, 1'b0, 1'b0, "wrap0");
        cycle(1'b0, TCOUNT_ADDR, 32'h0, 1'b1, 32'hFFFF_FFFF, 8'h00, 1'b0, 1'b0, "wrap1");
        cycle(1'b0, TCOUNT_ADDR, 32'h0, 1'b1, 32'h0000_0000, 8'h00, 1'b0, 1'b0, "wrap2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
